// File: rtl/reel_spin_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reel_spin_ctrl
// Description : Steps all reels from a programmable tick prescaler, then stops
//               them left to right with a fixed stagger. Reports the final
//               positions with a busy/done handshake. The optional macro
//               REEL_JITTER_EN adds 0..7 LFSR ticks to every reel's stop count.
// Revision    : 1.0 - initial release
// ============================================================================
module reel_spin_ctrl #(
    parameter int NUM_REELS  = 3,
    parameter int SYMBOLS    = 10,
    parameter int SYM_W      = 4,
    parameter int DIV_W      = 24,
    parameter int SPIN_STEPS = 20,
    parameter int STAGGER    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       div_load,
    input  logic [DIV_W-1:0]           div_value,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       step_tick,
    output logic [NUM_REELS-1:0]       reel_moving,
    output logic [NUM_REELS*SYM_W-1:0] reel_pos
);

    localparam int                STEP_W    = 16;
    localparam logic [DIV_W-1:0]  DIV_RESET = DIV_W'(10);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SYMBOLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SPIN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [DIV_W-1:0]           div_reg_q, div_reg_d;
    logic [DIV_W-1:0]           cnt_q, cnt_d;
    logic [STEP_W-1:0]          step_q, step_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [NUM_REELS-1:0]       moving_q, moving_d;
    logic [NUM_REELS*SYM_W-1:0] pos_q, pos_d;
    logic [STEP_W-1:0]          step_inc;
    logic [STEP_W-1:0]          stop_cnt [NUM_REELS];
    logic [2:0]                 jitter_q;

`ifdef REEL_JITTER_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] jitter_d;

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR; offset captured at start.
    always_comb begin
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        jitter_d = jitter_q;
        if (state_q == S_IDLE && start) begin
            jitter_d = lfsr_q[2:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q   <= 8'hA5;
            jitter_q <= 3'd0;
        end else begin
            lfsr_q   <= lfsr_d;
            jitter_q <= jitter_d;
        end
    end
`else
    assign jitter_q = 3'd0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REELS; i++) begin
            stop_cnt[i] = STEP_W'(SPIN_STEPS + i * STAGGER) + STEP_W'(jitter_q);
        end
    end

    assign step_tick = (state_q == S_SPIN) && (cnt_q == div_reg_q);
    assign step_inc  = step_q + STEP_W'(1);

    always_comb begin
        state_d   = state_q;
        div_reg_d = div_reg_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        moving_d  = moving_q;
        pos_d     = pos_q;
        case (state_q)
            S_IDLE: begin
                // A coincident load lands in div_reg_q before the first compare.
                if (div_load) begin
                    div_reg_d = div_value;
                end
                if (start) begin
                    state_d  = S_SPIN;
                    cnt_d    = '0;
                    step_d   = '0;
                    busy_d   = 1'b1;
                    moving_d = '1;
                end
            end
            S_SPIN: begin
                if (step_tick) begin
                    cnt_d  = '0;
                    step_d = step_inc;
                    for (int i = 0; i < NUM_REELS; i++) begin
                        if (moving_q[i]) begin
                            pos_d[i*SYM_W +: SYM_W] = (pos_q[i*SYM_W +: SYM_W] == SYM_LAST) ?
                                '0 : pos_q[i*SYM_W +: SYM_W] + SYM_W'(1);
                            if (step_inc == stop_cnt[i]) begin
                                moving_d[i] = 1'b0;
                            end
                        end
                    end
                    if (step_inc == stop_cnt[NUM_REELS-1]) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_reg_q <= DIV_RESET;
            cnt_q     <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            moving_q  <= '0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_reg_q <= div_reg_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            moving_q  <= moving_d;
            pos_q     <= pos_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign reel_moving = moving_q;
    assign reel_pos    = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_reel_spin_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reel_spin_ctrl
// Description : Directed self-checking bench for reel_spin_ctrl (jitter off).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reel_spin_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_load;
    logic [23:0] div_value;
    logic        start;
    logic        busy;
    logic        done;
    logic        step_tick;
    logic [2:0]  reel_moving;
    logic [11:0] reel_pos;

    int checks   = 0;
    int failures = 0;
    int exp_pos [3];

    always #5 clk = ~clk;

    reel_spin_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .div_load    (div_load),
        .div_value   (div_value),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .step_tick   (step_tick),
        .reel_moving (reel_moving),
        .reel_pos    (reel_pos)
    );

    // Reel i advances 20 + 5*i steps per spin, modulo 10 symbols.
    task automatic advance_model();
        for (int i = 0; i < 3; i++) begin
            exp_pos[i] = (exp_pos[i] + 20 + 5 * i) % 10;
        end
    endtask

    function automatic logic [11:0] exp_vec();
        return {exp_pos[2][3:0], exp_pos[1][3:0], exp_pos[0][3:0]};
    endfunction

    // Returns at the negedge just after the start edge (elapsed count 0).
    task automatic do_start(input logic ld, input logic [23:0] val);
        @(negedge clk);
        start     = 1'b1;
        div_load  = ld;
        div_value = val;
        @(negedge clk);
        start    = 1'b0;
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; div_load = 1'b0; div_value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) exp_pos[i] = 0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (step_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", step_tick); end
        checks++; if (reel_moving !== 3'b000) begin failures++; $display("FAIL reset_moving got=%b exp=000", reel_moving); end
        checks++; if (reel_pos !== 12'h000) begin failures++; $display("FAIL reset_pos got=%h exp=000", reel_pos); end
    endtask

    // Assumes div_reg = 10: tick every 11 cycles, done 330 cycles after start.
    task automatic test_tick_period();
        int el = 0;
        do_start(1'b0, 24'd0);
        checks++; if (busy !== 1'b1 || reel_moving !== 3'b111) begin
            failures++; $display("FAIL tp_busy got=%b/%b exp=1/111", busy, reel_moving); end
        while (!step_tick && el < 100) begin @(negedge clk); el++; end
        checks++; if (el !== 10) begin failures++; $display("FAIL tp_first_tick got=%0d exp=10", el); end
        @(negedge clk); el++;
        while (!step_tick && el < 100) begin @(negedge clk); el++; end
        checks++; if (el !== 21) begin failures++; $display("FAIL tp_second_tick got=%0d exp=21", el); end
        while (!done && el < 1000) begin @(negedge clk); el++; end
        advance_model();
        checks++; if (el !== 330) begin failures++; $display("FAIL tp_done_time got=%0d exp=330", el); end
        checks++; if (reel_pos !== exp_vec()) begin failures++; $display("FAIL tp_pos got=%h exp=%h", reel_pos, exp_vec()); end
        checks++; if (busy !== 1'b0 || reel_moving !== 3'b000) begin
            failures++; $display("FAIL tp_end_state got=%b/%b exp=0/000", busy, reel_moving); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL tp_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_stagger();
        @(negedge clk); div_load = 1'b1; div_value = 24'd0;
        @(negedge clk); div_load = 1'b0;
        do_start(1'b0, 24'd0);
        for (int el = 0; el <= 30; el++) begin
            if (el == 19) begin checks++; if (reel_moving !== 3'b111) begin
                failures++; $display("FAIL st_mov19 got=%b exp=111", reel_moving); end end
            if (el == 20) begin checks++; if (reel_moving !== 3'b110) begin
                failures++; $display("FAIL st_mov20 got=%b exp=110", reel_moving); end end
            if (el == 24) begin checks++; if (reel_moving !== 3'b110) begin
                failures++; $display("FAIL st_mov24 got=%b exp=110", reel_moving); end end
            if (el == 25) begin checks++; if (reel_moving !== 3'b100) begin
                failures++; $display("FAIL st_mov25 got=%b exp=100", reel_moving); end end
            if (el == 29) begin checks++; if (done !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL st_early got=%b/%b exp=0/1", done, busy); end end
            if (el < 30) @(negedge clk);
        end
        advance_model();
        checks++; if (done !== 1'b1 || reel_moving !== 3'b000) begin
            failures++; $display("FAIL st_done got=%b/%b exp=1/000", done, reel_moving); end
        checks++; if (reel_pos !== exp_vec()) begin failures++; $display("FAIL st_pos got=%h exp=%h", reel_pos, exp_vec()); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL st_done_pulse got=%b exp=0", done); end
    endtask

    // div_reg = 0 here: 30-cycle spins.
    task automatic test_back_to_back();
        int el = 0;
        do_start(1'b0, 24'd0);
        while (!done && el < 200) begin
            start = (el == 10);
            @(negedge clk); el++;
        end
        start = 1'b0;
        advance_model();
        checks++; if (el !== 30) begin failures++; $display("FAIL b2b_first_done got=%0d exp=30", el); end
        start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL b2b_done_ignore got=%b/%b exp=0/0", busy, done); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        el = 0;
        while (!done && el < 200) begin @(negedge clk); el++; end
        advance_model();
        checks++; if (el !== 30) begin failures++; $display("FAIL b2b_second_done got=%0d exp=30", el); end
        checks++; if (reel_pos !== exp_vec()) begin failures++; $display("FAIL b2b_pos got=%h exp=%h", reel_pos, exp_vec()); end
    endtask

    task automatic test_div_load_spin();
        int el = 0;
        do_start(1'b0, 24'd0);
        while (!done && el < 200) begin
            div_load  = (el == 5);
            div_value = 24'd3;
            @(negedge clk); el++;
        end
        div_load = 1'b0;
        advance_model();
        checks++; if (el !== 30) begin failures++; $display("FAIL dl_spin_done got=%0d exp=30", el); end
        do_start(1'b1, 24'd3);
        el = 0;
        while (!step_tick && el < 100) begin @(negedge clk); el++; end
        checks++; if (el !== 3) begin failures++; $display("FAIL dl_first_tick got=%0d exp=3", el); end
        while (!done && el < 1000) begin @(negedge clk); el++; end
        advance_model();
        checks++; if (el !== 120) begin failures++; $display("FAIL dl_done_time got=%0d exp=120", el); end
        checks++; if (reel_pos !== exp_vec()) begin failures++; $display("FAIL dl_pos got=%h exp=%h", reel_pos, exp_vec()); end
    endtask

    // div_reg = 3 here; abort on the 12th tick.
    task automatic test_reset_mid_spin();
        int ticks = 0;
        int el = 0;
        do_start(1'b0, 24'd0);
        while (ticks < 12 && el < 1000) begin
            if (step_tick) ticks++;
            if (ticks < 12) begin @(negedge clk); el++; end
        end
        checks++; if (ticks !== 12 || busy !== 1'b1) begin
            failures++; $display("FAIL rm_reach_tick got=%0d/%b exp=12/1", ticks, busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || reel_moving !== 3'b000 || reel_pos !== 12'h000 || step_tick !== 1'b0) begin
            failures++; $display("FAIL rm_async got=%b/%b/%h/%b exp=0/000/000/0", busy, reel_moving, reel_pos, step_tick); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL rm_no_done got=%b exp=0", done); end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_pos[i] = 0;
        test_tick_period();
    endtask

    initial begin
        test_reset();
        test_tick_period();
        test_stagger();
        test_back_to_back();
        test_div_load_spin();
        test_reset_mid_spin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
